// File: rtl/rv32_pkg.sv
// Shared fetch-path types and constants for fetch_ctrl and its redirect mux.
package rv32_pkg;

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_HOLD = 3'd2,
    S_KILL = 3'd3,
    S_HALT = 3'd4
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INSTR_BYTES          = 32'd4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_redirect_mux.sv
// Trap-over-branch redirect select with target alignment handling.
// FETCH_CTRL_MISALIGN_CHK_EN reports misaligned targets instead of masking them.
module fetch_redirect_mux
  import rv32_pkg::*;
(
  input  logic        trap_valid_i,
  input  logic [31:0] trap_pc_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        redir_o,
  output logic [31:0] target_o,
  output logic        misalign_o
);

  logic [31:0] sel_pc_s;

  // Priority select of the redirect target and its alignment status.
  always_comb begin
    redir_o = trap_valid_i | redirect_valid_i;
    if (trap_valid_i) begin
      sel_pc_s = trap_pc_i;
    end else begin
      sel_pc_s = redirect_pc_i;
    end
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
    target_o   = sel_pc_s;
    misalign_o = redir_o & is_misaligned(sel_pc_s);
`else
    target_o   = sel_pc_s & 32'hFFFF_FFFC;
    misalign_o = 1'b0;
`endif
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives the PC register, one outstanding imem request, decode handshake.
// Optional misaligned-redirect halt is enabled by FETCH_CTRL_MISALIGN_CHK_EN.
module fetch_ctrl
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_next_o,
  output logic        pc_en_o,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        trap_valid_i,
  input  logic [31:0] trap_pc_i
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
  ,
  output logic        fetch_misalign_o
`endif
);

  fetch_state_t state_q, state_d;
  fetch_state_t redir_dst_s, kill_dst_s;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  target_s;
  logic         redir_s, bad_s, load_s, accept_s;
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
  logic         pend_q, pend_d;
`endif

  fetch_redirect_mux u_redirect_mux (
    .trap_valid_i     (trap_valid_i),
    .trap_pc_i        (trap_pc_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .redir_o          (redir_s),
    .target_o         (target_s),
    .misalign_o       (bad_s)
  );

  assign imem_req_addr_o = pc_i;
  assign instr_pc_o      = pc_i;

  // Where a redirect or a drained kill lands: halt after a misaligned target.
  always_comb begin
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
    if (bad_s) begin
      redir_dst_s = S_HALT;
    end else begin
      redir_dst_s = S_REQ;
    end
    if (pend_q) begin
      kill_dst_s = S_HALT;
    end else begin
      kill_dst_s = S_REQ;
    end
`else
    redir_dst_s = S_REQ;
    kill_dst_s  = S_REQ;
`endif
  end

  // Next-state, fetch/decode handshakes and PC update selection.
  always_comb begin
    state_d          = state_q;
    buf_d            = buf_q;
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
    pend_d           = pend_q;
`endif
    imem_req_valid_o = 1'b0;
    instr_valid_o    = 1'b0;
    instr_o          = buf_q;
    pc_en_o          = 1'b0;
    pc_next_o        = pc_i;
    load_s           = redir_s & ~bad_s;
    case (state_q)
      S_REQ: begin
        imem_req_valid_o = ~redir_s;
        if (redir_s) begin
          state_d = redir_dst_s;
        end else if (imem_req_ready_i) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        instr_o       = imem_rsp_data_i;
        instr_valid_o = imem_rsp_valid_i & ~redir_s;
        if (redir_s) begin
          if (imem_rsp_valid_i) begin
            state_d = redir_dst_s;
          end else begin
            state_d = S_KILL;
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
            pend_d  = bad_s;
`endif
          end
        end else if (imem_rsp_valid_i) begin
          if (instr_ready_i) begin
            state_d = S_REQ;
          end else begin
            buf_d   = imem_rsp_data_i;
            state_d = S_HOLD;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        instr_valid_o = ~redir_s;
        if (redir_s) begin
          state_d = redir_dst_s;
        end else if (instr_ready_i) begin
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_KILL: begin
        if (imem_rsp_valid_i) begin
          if (redir_s) begin
            state_d = redir_dst_s;
          end else begin
            state_d = kill_dst_s;
          end
        end else begin
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
          if (redir_s) begin
            pend_d = bad_s;
          end else begin
            pend_d = pend_q;
          end
`endif
          state_d = S_KILL;
        end
      end
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
      // Only an aligned trap can restart fetch once halted.
      S_HALT: begin
        load_s = trap_valid_i & ~bad_s;
        if (load_s) begin
          state_d = S_REQ;
        end else begin
          state_d = S_HALT;
        end
      end
`endif
      default: begin
        state_d = S_REQ;
      end
    endcase

    accept_s = instr_valid_o & instr_ready_i;
    if (rst) begin
      imem_req_valid_o = 1'b0;
      instr_valid_o    = 1'b0;
      pc_en_o          = 1'b1;
      pc_next_o        = RESET_VECTOR;
    end else if (load_s) begin
      pc_en_o   = 1'b1;
      pc_next_o = target_s;
    end else if (accept_s) begin
      pc_en_o   = 1'b1;
      pc_next_o = pc_i + INSTR_BYTES;
    end else begin
      pc_en_o   = 1'b0;
      pc_next_o = pc_i;
    end
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
    fetch_misalign_o = ~rst & bad_s;
`endif
  end

  // State and holding buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      buf_q   <= 32'h0000_0000;
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
      pend_q  <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios, then randomized traffic
// against a transaction-level PC/memory/decode model.
module tb_fetch_ctrl;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, imem_req_ready, imem_rsp_valid, instr_ready, br_v, tr_v;
  logic [31:0] pc_drv, imem_rsp_data, br_pc, tr_pc;
  logic [31:0] pc_next, req_addr, instr, instr_pc;
  logic        pc_en, req_valid, instr_valid;
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .pc_i             (pc_drv),
    .pc_next_o        (pc_next),
    .pc_en_o          (pc_en),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (imem_req_ready),
    .imem_req_addr_o  (req_addr),
    .imem_rsp_valid_i (imem_rsp_valid),
    .imem_rsp_data_i  (imem_rsp_data),
    .instr_valid_o    (instr_valid),
    .instr_ready_i    (instr_ready),
    .instr_o          (instr),
    .instr_pc_o       (instr_pc),
    .redirect_valid_i (br_v),
    .redirect_pc_i    (br_pc),
    .trap_valid_i     (tr_v),
    .trap_pc_i        (tr_pc)
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
    ,
    .fetch_misalign_o (misalign)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: PC register, single-slot memory, halt flag, delivery log.
  logic [31:0] pc_m = 32'h0;
  logic [31:0] mem_addr = 32'h0;
  bit          mem_busy = 1'b0, mem_stale = 1'b0, halted = 1'b0, req_pend = 1'b0;
  int          mem_cnt = 0, lat = 1, cyc = 0, idle = 0;
  logic [31:0] log_pc[$];
  int          log_cyc[$];

  // Values seen in the most recent cycle, for directed checks.
  logic        l_pc_en, l_req_valid, l_instr_valid, l_misalign;
  logic [31:0] l_pc_next, l_req_addr, l_instr;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fx(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic tick();
    logic        sel_v, bad, load, hs, c_rst, c_req_hs, c_sel;
    logic [31:0] sel, exp_next, c_addr;
    pc_drv         = pc_m;
    imem_rsp_valid = mem_busy && (mem_cnt == 0);
    imem_rsp_data  = imem_rsp_valid ? fx(mem_addr) : $urandom;
    #1;
    sel_v = tr_v | br_v;
    sel   = tr_v ? tr_pc : br_pc;
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
    bad   = sel_v && (sel[1:0] != 2'b00);
    load  = sel_v && !bad && (!halted || tr_v);
`else
    bad   = 1'b0;
    sel   = sel & 32'hFFFF_FFFC;
    load  = sel_v;
`endif
    hs = instr_valid && instr_ready;
    if (rst) begin
      check32("rst_pc_en", pc_en, 32'd1);
      check32("rst_pc_next", pc_next, RV);
      check32("rst_req_valid", req_valid, 32'd0);
      check32("rst_instr_valid", instr_valid, 32'd0);
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
      check32("rst_misalign", misalign, 32'd0);
`endif
      idle = 0;
    end else begin
      exp_next = load ? sel : (hs ? pc_m + 32'd4 : pc_m);
      check32("pc_en", pc_en, {31'd0, load | hs});
      check32("pc_next", pc_next, exp_next);
      check32("req_addr", req_addr, pc_m);
      check32("instr_pc", instr_pc, pc_m);
      check32("req_outstanding", req_valid & mem_busy, 32'd0);
      check32("valid_on_redirect", instr_valid & sel_v, 32'd0);
      if (instr_valid) check32("instr_data", instr, fx(pc_m));
      if (imem_rsp_valid && !sel_v) check32("rsp_delivery", instr_valid, {31'd0, !mem_stale});
      if (req_pend && !sel_v) check32("req_withdrawn", req_valid, 32'd1);
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
      check32("misalign", misalign, {31'd0, bad});
      check32("req_halted", req_valid & (halted | bad), 32'd0);
`endif
      if (instr_valid) idle = 0;
      else idle++;
      if (idle > 40) begin
        check32("liveness_idle_cycles", idle, 32'd0);
        idle = 0;
      end
    end
    l_pc_en = pc_en; l_pc_next = pc_next; l_req_valid = req_valid; l_req_addr = req_addr;
    l_instr_valid = instr_valid; l_instr = instr;
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
    l_misalign = misalign;
`else
    l_misalign = 1'b0;
`endif
    c_rst = rst; c_req_hs = req_valid & imem_req_ready; c_addr = req_addr; c_sel = sel_v;
    req_pend = req_valid & ~imem_req_ready & ~rst;
    @(posedge clk);
    #1;
    if (l_pc_en) pc_m = l_pc_next;
    if (c_rst) begin
      mem_busy = 1'b0; mem_stale = 1'b0; halted = 1'b0;
    end else begin
      if (c_req_hs) begin
        mem_busy = 1'b1; mem_stale = 1'b0; mem_addr = c_addr; mem_cnt = lat - 1;
      end else if (mem_busy) begin
        if (mem_cnt == 0) mem_busy = 1'b0;
        else begin
          mem_cnt--;
          if (c_sel) mem_stale = 1'b1;
        end
      end
      if (bad) halted = 1'b1;
      else if (load) halted = 1'b0;
      if (hs) begin
        log_pc.push_back(pc_drv);
        log_cyc.push_back(cyc);
      end
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    br_v = 1'b0; tr_v = 1'b0; br_pc = 32'h0; tr_pc = 32'h0;
    pc_drv = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    @(posedge clk);
    #1;
    repeat (3) tick();

    // Reset release and back-to-back streaming with latency 1.
    rst = 1'b0;
    log_pc.delete(); log_cyc.delete();
    tick();
    check32("first_req_valid", l_req_valid, 32'd1);
    check32("first_req_addr", l_req_addr, RV);
    repeat (5) tick();
    check32("stream_count", log_pc.size(), 32'd3);
    if (log_pc.size() >= 3) begin
      check32("stream_pc0", log_pc[0], RV);
      check32("stream_pc1", log_pc[1], RV + 32'h4);
      check32("stream_pc2", log_pc[2], RV + 32'h8);
      check32("stream_gap01", log_cyc[1] - log_cyc[0], 32'd2);
      check32("stream_gap12", log_cyc[2] - log_cyc[1], 32'd2);
    end

    // Decode stall: word held stable, PC frozen, no new request.
    instr_ready = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check32("stall_valid", l_instr_valid, 32'd1);
      check32("stall_instr", l_instr, fx(RV + 32'hC));
      check32("stall_req", l_req_valid, 32'd0);
      check32("stall_pc_en", l_pc_en, 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    check32("stall_release_en", l_pc_en, 32'd1);
    check32("stall_release_pc", l_pc_next, RV + 32'h10);

    // Redirect while awaiting the response: stale word must be dropped.
    lat = 2;
    tick();
    br_v = 1'b1; br_pc = RV + 32'h100;
    tick();
    check32("kill_redirect_pc", l_pc_next, RV + 32'h100);
    br_v = 1'b0;
    log_pc.delete(); log_cyc.delete();
    tick();
    check32("kill_drop", l_instr_valid, 32'd0);
    lat = 1;
    repeat (4) tick();
    check32("kill_next_count", log_pc.size() >= 1, 32'd1);
    if (log_pc.size() >= 1) check32("kill_next_pc", log_pc[0], RV + 32'h100);

    // Trap beats branch in the same cycle.
    tr_v = 1'b1; tr_pc = RV + 32'h40; br_v = 1'b1; br_pc = RV + 32'h200;
    tick();
    check32("prio_pc_next", l_pc_next, RV + 32'h40);
    check32("prio_pc_loaded", pc_m, RV + 32'h40);
    tr_v = 1'b0; br_v = 1'b0;
    repeat (2) tick();

    // Misaligned redirect target.
    br_v = 1'b1; br_pc = RV + 32'h102;
    tick();
    br_v = 1'b0;
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
    check32("mis_pulse", l_misalign, 32'd1);
    check32("mis_pc_en", l_pc_en, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check32("mis_halt_req", l_req_valid, 32'd0);
      check32("mis_pulse_once", l_misalign, 32'd0);
    end
    tr_v = 1'b1; tr_pc = RV + 32'h40;
    tick();
    tr_v = 1'b0;
    check32("mis_resume_en", l_pc_en, 32'd1);
    check32("mis_resume_pc", l_pc_next, RV + 32'h40);
    log_pc.delete(); log_cyc.delete();
    repeat (2) tick();
    check32("mis_fetch_count", log_pc.size(), 32'd1);
    if (log_pc.size() >= 1) check32("mis_fetch_pc", log_pc[0], RV + 32'h40);
`else
    check32("align_mask_pc", l_pc_next, RV + 32'h100);
    log_pc.delete(); log_cyc.delete();
    repeat (2) tick();
    check32("align_fetch_count", log_pc.size(), 32'd1);
    if (log_pc.size() >= 1) check32("align_fetch_pc", log_pc[0], RV + 32'h100);
`endif

    // PC wraps from the top of the address space to zero.
    br_v = 1'b1; br_pc = 32'hFFFF_FFFC;
    tick();
    br_v = 1'b0;
    repeat (2) tick();
    check32("wrap_pc_next", l_pc_next, 32'h0000_0000);
    check32("wrap_pc_en", l_pc_en, 32'd1);

    // Randomized traffic.
    log_pc.delete(); log_cyc.delete();
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 299) == 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      lat            = $urandom_range(1, 3);
      br_v           = ($urandom_range(0, 9) == 0);
      tr_v           = ($urandom_range(0, 19) == 0);
      br_pc          = $urandom;
      tr_pc          = $urandom;
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
      br_pc[1:0]     = 2'b00;
      tr_pc[1:0]     = 2'b00;
`endif
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the `program_counter` register and the instruction-memory fetch port. It drives the PC's `pc_next_i`/`en`, issues one instruction fetch at a time over a valid/ready request port, and hands fetched words to decode with a valid/ready handshake. It also arbitrates PC redirects: trap beats branch/jump, which beats sequential +4. It sits between `program_counter`, instruction memory and decode.

## Interface
- `RESET_VECTOR`, 32'h8000_0000, PC value loaded during reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc_i` in 32: current PC from `program_counter.pc_o`.
- `pc_next_o` out 32: to `program_counter.pc_next_i`.
- `pc_en_o` out 1: to `program_counter.en`.
- `imem_req_valid_o` out 1: fetch request valid.
- `imem_req_ready_i` in 1: memory accepts request.
- `imem_req_addr_o` out 32: fetch address, always equals `pc_i`.
- `imem_rsp_valid_i` in 1: response word valid, one cycle pulse.
- `imem_rsp_data_i` in 32: response word.
- `instr_valid_o` out 1: instruction to decode valid.
- `instr_ready_i` in 1: decode accepts.
- `instr_o` out 32: instruction word.
- `instr_pc_o` out 32: PC of `instr_o`, equals `pc_i`.
- `redirect_valid_i` in 1: branch/jump taken.
- `redirect_pc_i` in 32: branch/jump target.
- `trap_valid_i` in 1: trap/mret redirect.
- `trap_pc_i` in 32: trap target.
- `fetch_misalign_o` out 1: present only with `FETCH_CTRL_MISALIGN_CHK_EN`; one-cycle pulse.

## Operation
- States: `S_REQ` (issue fetch), `S_WAIT` (await response), `S_HOLD` (buffered word, decode stalled), `S_KILL` (drop one stale response), `S_HALT` (misalign, macro only).
- Redirect source: `trap_valid_i` wins and uses `trap_pc_i`. Otherwise `redirect_valid_i` uses `redirect_pc_i`. Call the combined signal `redir`.
- On `redir`, in any state: `pc_en_o`=1 and `pc_next_o` = target.
- Sequential advance happens when an instruction handshake completes (`instr_valid_o & instr_ready_i`) with no `redir`: `pc_en_o`=1, `pc_next_o`=`pc_i`+4, 32-bit wrap (0xFFFF_FFFC → 0).
- Otherwise `pc_en_o`=0 and `pc_next_o`=`pc_i`.
- `S_REQ`:
  - `imem_req_valid_o` = ~`redir`. A request may be withdrawn only by a redirect.
  - Handshake → `S_WAIT`.
  - `redir` → stay in `S_REQ`.
- `S_WAIT`:
  - `instr_valid_o` = `imem_rsp_valid_i` & ~`redir`, with `instr_o` = `imem_rsp_data_i` (bypass).
  - Response accepted by decode → `S_REQ`.
  - Response not accepted → latch the word, go to `S_HOLD`.
  - `redir` with a response in the same cycle: response dropped → `S_REQ`.
  - `redir` with no response: → `S_KILL`.
- `S_HOLD`:
  - `instr_valid_o` = ~`redir`, `instr_o` = buffer.
  - Accept → `S_REQ`.
  - `redir` → buffer discarded → `S_REQ`.
- `S_KILL`:
  - All outputs to decode and memory idle.
  - Response → `S_REQ`.
  - A further `redir` reloads the PC and keeps the state in `S_KILL`.
- A response outside `S_WAIT`/`S_KILL` is a protocol error and is ignored.
- At most one request is outstanding.

## Timing
- During `rst`:
  - `pc_en_o`=1, `pc_next_o`=`RESET_VECTOR`.
  - `imem_req_valid_o`=0, `instr_valid_o`=0, `fetch_misalign_o`=0.
  - State ← `S_REQ`, buffer ← 0.
- First request: the cycle after `rst` falls, with address `RESET_VECTOR`.
- Memory response latency is ≥1 cycle after the request handshake.
- Response reaches decode in the same cycle (0-cycle bypass).
- Best-case throughput: one instruction per 2 cycles (REQ, WAIT).
- Redirect: PC updates on the next edge. The next fetch request issues the cycle after, or after the stale response drains (`S_KILL`).
- `rst` mid-fetch aborts all state; a response arriving after reset ends while in `S_REQ` is ignored.

## Configuration
- Macro: `FETCH_CTRL_MISALIGN_CHK_EN`.
- With the macro, a selected redirect target with bits [1:0] ≠ 0:
  - PC is not loaded (`pc_en_o`=0) and `fetch_misalign_o` pulses for one cycle.
  - The in-flight word is killed as for a redirect, then the state enters `S_HALT`.
  - `S_HALT` issues nothing and leaves only on an aligned `trap_valid_i`, which loads the PC → `S_REQ`.
- Without the macro: target bits [1:0] are forced to 0, there is no `S_HALT`, and the port is absent.

## Structure
- Shared package `rv32_pkg`: state enum `fetch_state_t` (3-bit encoding), `RESET_VECTOR_DEFAULT` = 32'h8000_0000, `INSTR_BYTES` = 4.
- Sub-module `fetch_redirect_mux`: combinational trap/branch priority select plus the alignment check.
- FSM and buffer stay in `fetch_ctrl`.

## Test plan
- **Reset:** hold `rst` 3 cycles → `pc_next_o`=0x8000_0000 with `pc_en_o`=1; first `imem_req_addr_o`=0x8000_0000 one cycle after release.
- **Streaming:** memory with `imem_req_ready_i`=1 and latency 1, decode always ready → instructions at 0x8000_0000, 0x8000_0004, 0x8000_0008 arrive 2 cycles apart.
- **Decode stall:** `instr_ready_i`=0 for 4 cycles in `S_HOLD` → `instr_o` stable, `pc_en_o`=0, no request; release → PC +4.
- **Kill path:** `redirect_valid_i` to 0x8000_0100 in `S_WAIT` before the response → that response is dropped; next `instr_pc_o`=0x8000_0100.
- **Priority:** `trap_valid_i` (0x8000_0040) and `redirect_valid_i` (0x8000_0200) in the same cycle → PC = 0x8000_0040.
- **Misalign, macro on:** redirect to 0x8000_0102 → `fetch_misalign_o` pulses, PC unchanged, no requests; trap to 0x8000_0040 resumes fetch. Macro off: the same stimulus fetches 0x8000_0100.
